// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction fetch stage. Drives a 5-bit word address to a     |
// |            combinational instruction memory and latches the returned     |
// |            word into the fetch/decode register. It also handles stall,   |
// |            jr/jump/branch redirects and a halt instruction.              |
// |            State updates on the falling edge of clk.                     |
// | Ports    : clk            - clock (falling-edge active)                   |
// |            reset          - asynchronous, active-low reset                |
// |            instruction    - memory word at address pc                    |
// |            pc             - word address to instruction memory           |
// |            stall          - downstream not ready, hold fetch             |
// |            branch_taken / branch_offset - pc-relative branch             |
// |            jump / jump_target           - absolute jump                  |
// |            jr / jr_target               - register jump                  |
// |            ifid_instr / ifid_pc_plus1 / ifid_valid - fetch/decode reg    |
// |            halted         - halt instruction reached                     |
// |            stalled        - fetch held by stall                          |
// |            fetch_count    - saturating count of delivered instructions   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [4:0]  pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] ifid_instr,
  output logic [4:0]  ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic        stalled,
  output logic [7:0]  fetch_count
);

  localparam logic [31:0] C_HALT_WORD = 32'h0000_000C;
  localparam logic [7:0]  C_CNT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_pc;
  logic [31:0] r_ifid_instr;
  logic [4:0]  r_ifid_pc_plus1;
  logic        r_ifid_valid;
  logic        r_halted;
  logic        r_stalled;
  logic [7:0]  r_fetch_count;

  logic        w_redirect;
  logic [4:0]  w_target;
  logic [4:0]  w_pc_plus1;
  logic        w_is_halt;
  logic [7:0]  w_count_next;
  logic        w_unused_bits;

  // Only the low five bits of the target/offset inputs address the 32-word
  // memory. For the branch, the offset's low five bits give the same result
  // mod 32 as the full signed offset.
  assign w_unused_bits = ^{branch_offset[15:5], jump_target[25:5], jr_target[31:5]};

  always_comb begin
    w_redirect   = jr | jump | branch_taken;
    w_pc_plus1   = r_pc + 5'd1;
    w_is_halt    = (instruction == C_HALT_WORD);
    w_count_next = (r_fetch_count == C_CNT_MAX) ? r_fetch_count : r_fetch_count + 8'd1;
    // Priority: jr > jump > branch. The 5-bit add wraps modulo 32.
    if (jr) begin
      w_target = jr_target[4:0];
    end else if (jump) begin
      w_target = jump_target[4:0];
    end else begin
      w_target = r_ifid_pc_plus1 + branch_offset[4:0];
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_BOOT;
      r_pc            <= 5'd0;
      r_ifid_instr    <= 32'd0;
      r_ifid_pc_plus1 <= 5'd0;
      r_ifid_valid    <= 1'b0;
      r_halted        <= 1'b0;
      r_stalled       <= 1'b0;
      r_fetch_count   <= 8'd0;
    end else begin
      case (r_state)
        S_BOOT: begin
          // First edge after reset release only arms the fetch.
          r_state   <= S_RUN;
          r_stalled <= 1'b0;
        end
        S_RUN, S_HOLD: begin
          if (w_redirect) begin
            // Redirect overrides stall and any halt word being presented.
            r_pc         <= w_target;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= 32'd0;
            r_state      <= S_RUN;
            r_stalled    <= 1'b0;
          end else if (stall) begin
            r_state   <= S_HOLD;
            r_stalled <= 1'b1;
          end else begin
            r_ifid_instr    <= instruction;
            r_ifid_pc_plus1 <= w_pc_plus1;
            r_ifid_valid    <= 1'b1;
            r_fetch_count   <= w_count_next;
            r_stalled       <= 1'b0;
            if (w_is_halt) begin
              // Halt word is delivered once; pc freezes on its address.
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc    <= w_pc_plus1;
              r_state <= S_RUN;
            end
          end
        end
        S_HALT: begin
          r_ifid_valid <= 1'b0;
          r_halted     <= 1'b1;
          r_stalled    <= 1'b0;
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign pc            = r_pc;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc_plus1 = r_ifid_pc_plus1;
  assign ifid_valid    = r_ifid_valid;
  assign halted        = r_halted;
  assign stalled       = r_stalled;
  assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                 |
// | Purpose  : Self-checking bench for fetch_unit. Driver issues stimulus on |
// |            the rising edge and queues the predicted register contents;   |
// |            a monitor pops and compares after each falling edge.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  pc;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] ifid_instr;
  logic [4:0]  ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;
  logic        stalled;
  logic [7:0]  fetch_count;

  logic [31:0] mem [32];

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .instruction   (instruction),
    .pc            (pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .stalled       (stalled),
    .fetch_count   (fetch_count)
  );

  assign instruction = mem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   pc;
    int   instr;
    int   pp1;
    bit   valid;
    bit   halted;
    bit   stalled;
    int   cnt;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: architectural view of the fetch stage.
  bit m_booting;
  bit m_halted;
  bit m_stalled;
  bit m_valid;
  int m_pc;
  int m_instr;
  int m_pp1;
  int m_cnt;

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'h0000_000C) w = 32'h0000_0001;
    return w;
  endfunction

  task automatic model_reset();
    m_booting = 1; m_halted = 0; m_stalled = 0; m_valid = 0;
    m_pc = 0; m_instr = 0; m_pp1 = 0; m_cnt = 0;
  endtask

  task automatic predict(input bit s, input bit b, input logic [15:0] off,
                         input bit j, input logic [25:0] jt,
                         input bit r, input logic [31:0] rt);
    snap_t e;
    int t;
    if (m_booting) begin
      m_booting = 0;
      m_stalled = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (r || j || b) begin
      if (r)      t = int'(rt) & 31;
      else if (j) t = int'(jt) & 31;
      else begin
        t = (m_pp1 + int'($signed(off))) % 32;
        if (t < 0) t += 32;
      end
      m_pc = t; m_valid = 0; m_instr = 0; m_stalled = 0;
    end else if (s) begin
      m_stalled = 1;
    end else begin
      m_instr = int'(mem[m_pc]);
      m_pp1 = (m_pc + 1) % 32;
      m_valid = 1;
      m_stalled = 0;
      if (m_cnt < 255) m_cnt++;
      if (m_instr == 12) m_halted = 1;
      else m_pc = (m_pc + 1) % 32;
    end
    e.pc = m_pc; e.instr = m_instr; e.pp1 = m_pp1; e.valid = m_valid;
    e.halted = m_halted; e.stalled = m_stalled; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit s, input bit b, input logic [15:0] off,
                      input bit j, input logic [25:0] jt,
                      input bit r, input logic [31:0] rt);
    @(posedge clk); #1;
    stall = s; branch_taken = b; branch_offset = off;
    jump = j; jump_target = jt; jr = r; jr_target = rt;
    predict(s, b, off, j, jt, r, rt);
  endtask

  task automatic idle();
    step(0, 0, 16'd0, 0, 26'd0, 0, 32'd0);
  endtask

  task automatic settle();
    @(negedge clk); #2;
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (pc !== 5'd0 || ifid_instr !== 32'd0 || ifid_pc_plus1 !== 5'd0 ||
        ifid_valid !== 1'b0 || halted !== 1'b0 || stalled !== 1'b0 ||
        fetch_count !== 8'd0) begin
      errors++;
      $display("FAIL %s: got pc=%0d instr=%h pp1=%0d v=%b h=%b s=%b cnt=%0d expected all zero",
               name, pc, ifid_instr, ifid_pc_plus1, ifid_valid, halted, stalled, fetch_count);
    end
  endtask

  // Drops reset between clock edges, holds it across a falling edge with
  // busy inputs, then releases it just after a falling edge.
  task automatic do_reset(input string name);
    @(negedge clk); #3;
    reset = 0;
    #1;
    check_zero({name, "_immediate"});
    stall = 1; jump = 1; jump_target = 26'd9; jr = $urandom; branch_taken = 1;
    @(negedge clk); #1;
    check_zero({name, "_held"});
    #2;
    stall = 0; jump = 0; jr = 0; branch_taken = 0;
    reset = 1;
    model_reset();
  endtask

  // Monitor: compares the register view after every falling edge that has
  // a queued expectation.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(pc) != e.pc || int'(ifid_instr) != e.instr || int'(ifid_pc_plus1) != e.pp1 ||
            ifid_valid != e.valid || halted != e.halted || stalled != e.stalled ||
            int'(fetch_count) != e.cnt) begin
          errors++;
          $display("FAIL snapshot t=%0t: got pc=%0d instr=%h pp1=%0d v=%b h=%b s=%b cnt=%0d expected pc=%0d instr=%h pp1=%0d v=%b h=%b s=%b cnt=%0d",
                   $time, pc, ifid_instr, ifid_pc_plus1, ifid_valid, halted, stalled, fetch_count,
                   e.pc, e.instr, e.pp1, e.valid, e.halted, e.stalled, e.cnt);
        end
      end
    end
  end

  initial begin
    reset = 0; stall = 0; branch_taken = 0; branch_offset = 16'd0;
    jump = 0; jump_target = 26'd0; jr = 0; jr_target = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = rand_word();
    mem[0] = 32'h0062_2020; mem[1] = 32'h8C45_0BB8; mem[2] = 32'h1009_000A; mem[3] = 32'h0000_000C;
    model_reset();

    // Power-on reset held through a falling edge, then released.
    @(negedge clk); #1;
    check_zero("power_on_reset");
    #2; reset = 1;

    // Sequential fetch, then stall at pc=2, then halt at pc=3.
    idle();                 // boot edge
    idle(); idle();         // mem[0], mem[1]
    step(1, 0, 16'd0, 0, 26'd0, 0, 32'd0);
    step(1, 0, 16'd0, 0, 26'd0, 0, 32'd0);
    settle();
    check_val("stall_pc", int'(pc), 2);
    check_val("stall_flag", int'(stalled), 1);
    check_val("stall_hold_instr", int'(ifid_instr), int'(32'h8C45_0BB8));
    idle();                 // mem[2]
    settle();
    check_val("seq_count", int'(fetch_count), 3);
    check_val("seq_pc", int'(pc), 3);
    check_val("seq_pp1", int'(ifid_pc_plus1), 3);
    idle();                 // halt word delivered
    settle();
    check_val("halt_delivered_valid", int'(ifid_valid), 1);
    for (int i = 0; i < 4; i++) step($urandom, 0, 16'd0, $urandom, 26'd4, 0, 32'd0);
    settle();
    check_val("halt_valid_low", int'(ifid_valid), 0);
    check_val("halt_flag", int'(halted), 1);
    check_val("halt_pc_frozen", int'(pc), 3);
    do_reset("reset_in_halt");

    // Jump on the same edge as the halt word: no halt.
    idle(); idle(); idle(); idle();
    step(0, 0, 16'd0, 1, 26'd5, 0, 32'd0);
    settle();
    check_val("jump_beats_halt", int'(halted), 0);
    check_val("jump_beats_halt_pc", int'(pc), 5);

    // Redirect priority.
    step(0, 1, 16'd7, 1, 26'd4, 1, 32'h0000_0011);
    settle();
    check_val("prio_pc", int'(pc), 17);
    check_val("prio_valid", int'(ifid_valid), 0);

    // Branch sum wrap: ifid_pc_plus1=30, offset 3 -> 1.
    step(0, 0, 16'd0, 1, 26'd29, 0, 32'd0);
    idle();
    step(0, 1, 16'd3, 0, 26'd0, 0, 32'd0);
    settle();
    check_val("branch_wrap_pc", int'(pc), 1);

    // pc wrap 31 -> 0.
    step(0, 0, 16'd0, 1, 26'd31, 0, 32'd0);
    idle();
    settle();
    check_val("pc_wrap", int'(pc), 0);

    // Reset during a stall.
    step(1, 0, 16'd0, 0, 26'd0, 0, 32'd0);
    do_reset("reset_in_stall");

    // Saturation: 300 fetches with no halt word in memory.
    for (int i = 0; i < 32; i++) mem[i] = rand_word();
    idle();
    for (int i = 0; i < 300; i++) idle();
    settle();
    check_val("count_saturate", int'(fetch_count), 255);
    do_reset("reset_after_sat");

    // Randomized phase with occasional halt words and resets.
    for (int i = 0; i < 32; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0000_000C : rand_word();
    mem[0] = rand_word();
    for (int n = 0; n < 600; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        do_reset("reset_random");
      end else begin
        step($urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0, 16'($urandom),
             $urandom_range(0, 9) == 0, 26'($urandom),
             $urandom_range(0, 11) == 0, $urandom);
      end
    end
    settle();
    check_val("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on falling edge (matches program_counter).
REQ-002 SHALL have: reset  in  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-003 SHALL have: instruction  in  32  word returned by instruction_memory for address pc (combinational).
REQ-004 SHALL have: pc  out  5  word address driven to instruction_memory.
REQ-005 SHALL have: stall  in  1  downstream not ready; hold fetch.
REQ-006 SHALL have: branch_taken  in  1; branch_offset  in  16  signed word offset, relative to ifid_pc_plus1.
REQ-007 SHALL have: jump  in  1; jump_target  in  26  word target, bits [4:0] used.
REQ-008 SHALL have: jr  in  1; jr_target  in  32  register value, bits [4:0] used.
REQ-009 SHALL have: ifid_instr  out  32; ifid_pc_plus1  out  5; ifid_valid  out  1  (fetch/decode register).
REQ-010 SHALL have: halted  out  1; stalled  out  1 (state==HOLD); fetch_count  out  8  delivered-instruction count.

Function
REQ-011 SHALL implement states BOOT, RUN, HOLD, HALT; state encoding free.
REQ-012 BOOT: first falling edge after reset release -> RUN; pc, ifid_* unchanged; no fetch.
REQ-013 RUN/HOLD, no redirect, stall=0: ifid_instr<=instruction, ifid_pc_plus1<=pc+1, ifid_valid<=1, pc<=pc+1, state->RUN.
REQ-014 stall=1, no redirect: pc and all ifid_* hold, state->HOLD; no fetch_count change.
REQ-015 Redirect = jr|jump|branch_taken; priority jr > jump > branch_taken; only the winner takes effect.
REQ-016 Redirect targets: jr -> jr_target[4:0]; jump -> jump_target[4:0]; branch -> (ifid_pc_plus1 + branch_offset[4:0]) mod 32.
REQ-017 Redirect in RUN or HOLD: pc<=target, ifid_valid<=0 (bubble), ifid_instr<=0, state->RUN; overrides stall.
REQ-018 pc+1 and branch sums SHALL wrap modulo 32 (31+1=0; 30+offset 3 = 1).
REQ-019 Halt: when a fetch per REQ-013 latches instruction==32'h0000000C, it is delivered (valid=1), pc holds, state->HALT.
REQ-020 Redirect on the same edge as halt-instruction fetch wins; halt word discarded; no HALT entry.
REQ-021 HALT: next edge ifid_valid<=0; pc, ifid_instr hold; halted=1; redirect/stall ignored; exit only via reset.
REQ-022 fetch_count increments on every edge where ifid_valid is loaded with 1; saturates at 255.
REQ-023 Fetch latency: instruction at pc appears on ifid_instr one falling edge after pc presents it.

Reset
REQ-024 reset=0 SHALL asynchronously set pc=0, ifid_instr=0, ifid_pc_plus1=0, ifid_valid=0, fetch_count=0, halted=0, stalled=0, state=BOOT.
REQ-025 Reset asserted mid-stall, mid-redirect or in HALT SHALL behave identically to power-on reset; pending redirect discarded.
REQ-026 Outputs SHALL stay at reset values while reset=0 regardless of clk or inputs.

Verification
REQ-027 Sequential: mem[0..2]=0x00622020,0x8C450BB8,0x1009000A; release reset -> BOOT edge, then ifid_instr 0x00622020/pc_plus1 1, 0x8C450BB8/2, 0x1009000A/3; fetch_count=3.
REQ-028 Stall: assert stall 2 edges at pc=2 -> pc stays 2, ifid held, stalled=1; release -> next edge fetches mem[2], pc=3.
REQ-029 Redirect priority: jr=1 (jr_target=0x11), jump=1 (target 4), branch_taken=1 same edge -> pc=17, ifid_valid=0; branch alone with ifid_pc_plus1=30, offset 3 -> pc=1.
REQ-030 Halt: mem[3]=0x0000000C -> delivered valid=1, next edge valid=0, halted=1, pc=3 frozen under stall/jump toggling; same-edge jump instead -> no halt.
REQ-031 Wrap/saturation: pc=31 sequential -> pc=0; run 300 fetches -> fetch_count=255.
REQ-032 Async reset: drop reset between clock edges in HALT and during stall -> all outputs zero immediately; release -> BOOT then fetch mem[0].
